// File: rtl/ram_ctrl_pkg.sv
// Shared constants and types for the RAM arbiter slice.
// Sizes, FSM state encoding and requester ids.
package ram_ctrl_pkg;

  localparam int DATA_WIDTH = 32;
  localparam int ADDR_WIDTH = 5;
  localparam int DEPTH      = 1 << ADDR_WIDTH;

  localparam logic ST_INIT = 1'b0;
  localparam logic ST_ARB  = 1'b1;

  localparam int REQ_A = 0;
  localparam int REQ_B = 1;

  typedef struct packed {
    logic                  wen;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] din;
  } ram_req_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin grant with a last-grant pointer.
// Ports: clk, reset_n, req[1:0], enable in; gnt[1:0] out (one-hot or zero).
module rr_arbiter_2
  import ram_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

  logic last_q;
  logic last_d;

  // On a tie, the requester that did not win last time goes first.
  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      unique case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_q == 1'(REQ_B)) ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_comb begin
    last_d = last_q;
    unique case (1'b1)
      gnt[REQ_A]: last_d = 1'(REQ_A);
      gnt[REQ_B]: last_d = 1'(REQ_B);
      default:    last_d = last_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) last_q <= 1'(REQ_B);
    else          last_q <= last_d;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one 32x32 single-port RAM between requesters A and B, one access per clock,
// and routes read data back to the issuer. Ports: a_*/b_* clients, ram_* RAM side, busy.
// Build option RAM_INIT_EN: zero-fill the RAM after reset before any grant.
module ram_arbiter
  import ram_ctrl_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  a_req,
  input  logic                  a_wen,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_din,
  output logic                  a_gnt,
  output logic                  a_rvalid,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_wen,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_din,
  output logic                  b_gnt,
  output logic                  b_rvalid,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  ram_cen,
  output logic                  ram_wen,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic                  busy
);

  logic       in_arb;
  logic       init_act;
  logic [1:0] gnt;
  ram_req_t   a_r;
  ram_req_t   b_r;

  assign a_r = '{wen: a_wen, addr: a_addr, din: a_din};
  assign b_r = '{wen: b_wen, addr: b_addr, din: b_din};

`ifdef RAM_INIT_EN
  logic                  state_q;
  logic                  state_d;
  logic [ADDR_WIDTH-1:0] cnt_q;
  logic [ADDR_WIDTH-1:0] cnt_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (state_q == ST_INIT) begin
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == ADDR_WIDTH'(DEPTH - 1)) state_d = ST_ARB;
    end
  end

  assign in_arb   = (state_q == ST_ARB);
  // Outputs are forced quiet while reset is held.
  assign init_act = reset_n && (state_q == ST_INIT);
`else
  assign in_arb   = 1'b1;
  assign init_act = 1'b0;
`endif

  rr_arbiter_2 u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     ({b_req, a_req}),
    .enable  (in_arb && reset_n),
    .gnt     (gnt)
  );

  assign a_gnt = gnt[REQ_A];
  assign b_gnt = gnt[REQ_B];

  always_comb begin
    ram_cen  = 1'b0;
    ram_wen  = 1'b0;
    ram_addr = '0;
    ram_din  = '0;
    busy     = init_act;
    unique case (1'b1)
      init_act: begin
        ram_cen  = 1'b1;
        ram_wen  = 1'b1;
`ifdef RAM_INIT_EN
        ram_addr = cnt_q;
`endif
      end
      gnt[REQ_A]: begin
        ram_cen  = 1'b1;
        ram_wen  = a_r.wen;
        ram_addr = a_r.addr;
        ram_din  = a_r.din;
      end
      gnt[REQ_B]: begin
        ram_cen  = 1'b1;
        ram_wen  = b_r.wen;
        ram_addr = b_r.addr;
        ram_din  = b_r.din;
      end
      default: begin
        ram_cen = 1'b0;
      end
    endcase
  end

  // Read return: remember who issued the read; data arrives next cycle.
  logic                  rd_pending_q;
  logic                  rd_pending_d;
  logic                  rd_id_q;
  logic                  rd_id_d;
  logic [DATA_WIDTH-1:0] a_rdata_q;
  logic [DATA_WIDTH-1:0] a_rdata_d;
  logic [DATA_WIDTH-1:0] b_rdata_q;
  logic [DATA_WIDTH-1:0] b_rdata_d;

  always_comb begin
    rd_pending_d = 1'b0;
    rd_id_d      = rd_id_q;
    unique case (1'b1)
      gnt[REQ_A]: begin
        rd_pending_d = ~a_wen;
        rd_id_d      = 1'(REQ_A);
      end
      gnt[REQ_B]: begin
        rd_pending_d = ~b_wen;
        rd_id_d      = 1'(REQ_B);
      end
      default: begin
        rd_pending_d = 1'b0;
      end
    endcase
  end

  assign a_rvalid = rd_pending_q && (rd_id_q == 1'(REQ_A));
  assign b_rvalid = rd_pending_q && (rd_id_q == 1'(REQ_B));

  // The non-returning side keeps showing its last read word.
  always_comb begin
    a_rdata_d = a_rvalid ? ram_dout : a_rdata_q;
    b_rdata_d = b_rvalid ? ram_dout : b_rdata_q;
  end

  assign a_rdata = a_rdata_d;
  assign b_rdata = b_rdata_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pending_q <= 1'b0;
      rd_id_q      <= 1'(REQ_A);
      a_rdata_q    <= '0;
      b_rdata_q    <= '0;
    end else begin
      rd_pending_q <= rd_pending_d;
      rd_id_q      <= rd_id_d;
      a_rdata_q    <= a_rdata_d;
      b_rdata_q    <= b_rdata_d;
    end
  end

endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the 32x32 single-port synchronous RAM (cen/wen/addr/din/dout interface).
- Time-multiplexes the RAM between requester A and requester B, one access per clock.
- Returns read data to the requester that issued the read.
- Optionally zero-fills the RAM after reset before granting any access.
- Sits between the RAM and its two clients; it is the only driver of the RAM control inputs.

Parameters:
DATA_WIDTH, 32, RAM word width
ADDR_WIDTH, 5, RAM address width
DEPTH, 32, number of RAM words (2**ADDR_WIDTH)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
a_req  input  1  requester A access request; held until a_gnt
a_wen  input  1  A: 1=write, 0=read
a_addr  input  ADDR_WIDTH  A address
a_din  input  DATA_WIDTH  A write data
a_gnt  output  1  A access accepted this cycle
a_rvalid  output  1  A read data valid
a_rdata  output  DATA_WIDTH  A read data
b_req, b_wen, b_addr, b_din, b_gnt, b_rvalid, b_rdata  same as A, for requester B
ram_cen  output  1  RAM chip enable
ram_wen  output  1  RAM write enable
ram_addr  output  ADDR_WIDTH  RAM address
ram_din  output  DATA_WIDTH  RAM write data
ram_dout  input  DATA_WIDTH  RAM read data, valid the cycle after a read is sampled
busy  output  1  high while not in ARB state

Behaviour:
- Reset (async, reset_n=0):
  - All outputs 0.
  - last_grant pointer = B, so A wins the first tie.
  - rd_pending cleared.
  - State = INIT if RAM_INIT_EN is defined, else ARB.
- States: INIT, ARB.
  - INIT -> ARB when the init counter reaches DEPTH-1.
  - ARB has no exit except reset.
- ARB, grant selection (combinational, same cycle as req):
  - Only one requester asserts req: that requester is granted.
  - Both assert req: grant goes to the requester that is not last_grant.
  - last_grant updates on the clock edge of every grant.
  - Neither asserts req: no grant, ram_cen=0, and ram_addr/ram_din/ram_wen hold 0.
- ARB, RAM drive: in a grant cycle ram_cen=1, and ram_wen/ram_addr/ram_din are the granted requester's inputs, muxed combinationally.
- Fairness: a continuously requesting client waits at most 1 cycle between grants.
- Reads: a granted read in cycle N registers rd_pending=1 and rd_id (A/B).
  - In cycle N+1, the matching x_rvalid=1 and x_rdata=ram_dout.
  - The other requester's rvalid stays 0 and its rdata holds its last value.
  - Back-to-back reads give one rvalid per cycle in grant order.
- Writes: complete on the grant edge and produce no rvalid.
- Read-after-write to the same address in consecutive grants returns the new data, because the RAM is written at edge N.
- req deasserted without a grant: no effect, nothing is latched.
- Addresses are ADDR_WIDTH wide, so every address is valid and there is no wrap or bounds check.
- Reset asserted mid-operation:
  - A pending rvalid is dropped.
  - The INIT sweep restarts from address 0.

Optional Feature:
RAM_INIT_EN
- Defined:
  - After reset, state INIT drives ram_cen=1, ram_wen=1, ram_din=0, ram_addr=counter, with the counter running 0..DEPTH-1 over DEPTH cycles.
  - busy=1 and both gnt=0 throughout INIT.
  - Enters ARB on the cycle after address DEPTH-1 is written.
- Undefined:
  - The INIT state and counter are absent.
  - ARB is entered directly after reset; busy is constant 0.
  - RAM contents after reset are undefined.

Decomposition:
- Package ram_ctrl_pkg:
  - DATA_WIDTH/ADDR_WIDTH/DEPTH constants.
  - State encoding localparams ST_INIT, ST_ARB.
  - Requester id constants REQ_A=0, REQ_B=1.
- Sub-module rr_arbiter_2: 2-way round-robin grant logic plus last_grant register, with inputs req[1:0] and enable, and output gnt[1:0].
- The top level holds the FSM, init counter, RAM mux and read return path.

Test Plan:
- Reset with RAM_INIT_EN, then wait -> busy=1 for 32 cycles, ram_addr walks 0..31 with ram_din=0; then busy=0 and A reads addr 5 -> a_rvalid with a_rdata=0x00000000.
- A writes addr 1..4 with 0x1..0x4 on consecutive cycles, then reads addr 1..4 -> a_rvalid on 4 consecutive cycles with data 0x1,0x2,0x3,0x4 and b_rvalid=0 throughout.
- A and B both hold req for 6 cycles -> grants alternate A,B,A,B,A,B, with ram_addr following the granted requester each cycle.
- B writes addr 7=0xDEADBEEF; the next cycle A reads addr 7 -> a_rvalid one cycle later with a_rdata=0xDEADBEEF.
- A issues a read and reset_n is pulsed low before the data returns -> no a_rvalid is ever asserted, all outputs read 0, and the INIT sweep restarts at address 0.
- No requests for 5 cycles -> ram_cen=0, both gnt=0, both rvalid=0.
